// File: rtl/ifmap_buf_writer_pkg.sv
// Shared types and defaults for the ifmap buffer writer: FSM states and default widths.
package ifmap_buf_writer_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDimW  = 8;
    localparam int unsigned DefAddrW = 14;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDoneS = 2'd3
    } wr_state_e;

endpackage

// File: rtl/ifmap_buf_writer_if.sv
// AXI4-Stream ifmap element channel between the AXIS bridge (master) and the buffer writer (slave).
interface ifmap_buf_writer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ifmap_buf_writer_addr_gen.sv
// HWC-order element counters producing the CHW buffer address incrementally (no multiplier in loop).
module ifmap_buf_writer_addr_gen
    import ifmap_buf_writer_pkg::*;
#(
    parameter int unsigned DIM_W  = DefDimW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [DIM_W-1:0]  cfg_width_i,
    input  logic [DIM_W-1:0]  cfg_height_i,
    input  logic [DIM_W-1:0]  cfg_channels_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              last_elem_o
);

    logic [DIM_W-1:0]   width_q, width_d, height_q, height_d, chan_q, chan_d;
    logic [DIM_W-1:0]   c_q, c_d, x_q, x_d, r_q, r_d;
    logic [ADDR_W-1:0]  plane_q, plane_d, pix_base_q, pix_base_d, ptr_q, ptr_d;
    logic [2*DIM_W-1:0] plane_full;

    logic c_wrap, x_wrap, r_wrap;

    assign plane_full = cfg_height_i * cfg_width_i;
    assign c_wrap     = (c_q == chan_q - DIM_W'(1));
    assign x_wrap     = (x_q == width_q - DIM_W'(1));
    assign r_wrap     = (r_q == height_q - DIM_W'(1));

    always_comb begin
        width_d    = width_q;
        height_d   = height_q;
        chan_d     = chan_q;
        c_d        = c_q;
        x_d        = x_q;
        r_d        = r_q;
        plane_d    = plane_q;
        pix_base_d = pix_base_q;
        ptr_d      = ptr_q;
        if (load_i) begin
            width_d    = cfg_width_i;
            height_d   = cfg_height_i;
            chan_d     = cfg_channels_i;
            plane_d    = ADDR_W'(plane_full);
            pix_base_d = cfg_base_addr_i;
            ptr_d      = cfg_base_addr_i;
            c_d        = '0;
            x_d        = '0;
            r_d        = '0;
        end else if (advance_i) begin
            if (c_wrap) begin
                // Next pixel's channel-0 address is simply the previous pixel's plus one.
                c_d        = '0;
                ptr_d      = pix_base_q + ADDR_W'(1);
                pix_base_d = pix_base_q + ADDR_W'(1);
                if (x_wrap) begin
                    x_d = '0;
                    r_d = r_wrap ? '0 : r_q + DIM_W'(1);
                end else begin
                    x_d = x_q + DIM_W'(1);
                end
            end else begin
                c_d   = c_q + DIM_W'(1);
                ptr_d = ptr_q + plane_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            width_q    <= '0;
            height_q   <= '0;
            chan_q     <= '0;
            c_q        <= '0;
            x_q        <= '0;
            r_q        <= '0;
            plane_q    <= '0;
            pix_base_q <= '0;
            ptr_q      <= '0;
        end else begin
            width_q    <= width_d;
            height_q   <= height_d;
            chan_q     <= chan_d;
            c_q        <= c_d;
            x_q        <= x_d;
            r_q        <= r_d;
            plane_q    <= plane_d;
            pix_base_q <= pix_base_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ptr_o       = ptr_q;
    assign last_elem_o = c_wrap && x_wrap && r_wrap;

endmodule

// File: rtl/ifmap_buf_writer.sv
// Writes an HWC ifmap stream into the buffer in CHW layout and checks TLAST against W*H*C.
// Define IFMAP_WR_PIPE_EN to register the buffer write port (1-cycle latency, done delayed to match).
module ifmap_buf_writer
    import ifmap_buf_writer_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DIM_W  = DefDimW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic               S_AXIS_ACLK,
    input  logic               S_AXIS_ARESET,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [DIM_W-1:0]   cfg_channels,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    ifmap_buf_writer_if.slave  s_axis,
    output logic               buf_we,
    output logic [ADDR_W-1:0]  buf_addr,
    output logic [DATA_W-1:0]  buf_wdata,
    output logic               busy,
    output logic               done,
    output logic               err_early_last,
    output logic               err_late_last
);

    wr_state_e state_q, state_d;
    logic      err_early_q, err_early_d, err_late_q, err_late_d;
    logic      zero_dim, start_ok, hs, hs_run, last_elem;
    logic [ADDR_W-1:0] ptr;

    logic              buf_we_d, done_d;
    logic [ADDR_W-1:0] buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_d;

    assign zero_dim = (cfg_width == '0) || (cfg_height == '0) || (cfg_channels == '0);
    assign start_ok = start && (state_q == StIdle);
    assign s_axis.tready = (state_q == StRun) || (state_q == StDrain);
    assign hs       = s_axis.tvalid && s_axis.tready;
    assign hs_run   = hs && (state_q == StRun);

    ifmap_buf_writer_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i           (S_AXIS_ACLK),
        .rst_i           (S_AXIS_ARESET),
        .load_i          (start_ok),
        .advance_i       (hs_run),
        .cfg_width_i     (cfg_width),
        .cfg_height_i    (cfg_height),
        .cfg_channels_i  (cfg_channels),
        .cfg_base_addr_i (cfg_base_addr),
        .ptr_o           (ptr),
        .last_elem_o     (last_elem)
    );

    always_comb begin
        state_d     = state_q;
        err_early_d = err_early_q;
        err_late_d  = err_late_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_early_d = 1'b0;
                    err_late_d  = 1'b0;
                    state_d     = zero_dim ? StDoneS : StRun;
                end
            end
            StRun: begin
                if (hs) begin
                    if (last_elem) begin
                        if (s_axis.tlast) begin
                            state_d = StDoneS;
                        end else begin
                            err_late_d = 1'b1;
                            state_d    = StDrain;
                        end
                    end else if (s_axis.tlast) begin
                        err_early_d = 1'b1;
                        state_d     = StDoneS;
                    end
                end
            end
            StDrain: begin
                if (hs && s_axis.tlast) state_d = StDoneS;
            end
            StDoneS: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q     <= StIdle;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    // Address/data are forced to zero when idle so the port reads all-zero outside writes.
    assign buf_we_d    = hs_run;
    assign buf_addr_d  = hs_run ? ptr : '0;
    assign buf_wdata_d = hs_run ? s_axis.tdata : '0;
    assign done_d      = (state_q == StDoneS);

`ifdef IFMAP_WR_PIPE_EN
    logic              buf_we_q, done_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_wdata_q;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            done_q      <= done_d;
        end
    end

    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign done      = done_q;
`else
    assign buf_we    = buf_we_d;
    assign buf_addr  = buf_addr_d;
    assign buf_wdata = buf_wdata_d;
    assign done      = done_d;
`endif

    assign busy           = (state_q == StRun) || (state_q == StDrain);
    assign err_early_last = err_early_q;
    assign err_late_last  = err_late_q;

endmodule

// File: tb/tb_ifmap_buf_writer.sv
// Self-checking bench for ifmap_buf_writer: frame vector table plus scoreboard of expected writes.
module tb_ifmap_buf_writer;
    import ifmap_buf_writer_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIM_W  = 8;
    localparam int unsigned ADDR_W = 14;
`ifdef IFMAP_WR_PIPE_EN
    localparam int DoneLat = 2;
`else
    localparam int DoneLat = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_width = '0, cfg_height = '0, cfg_channels = '0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic              buf_we, busy, done, err_early_last, err_late_last;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;

    ifmap_buf_writer_if #(.DATA_W(DATA_W)) axis ();

    ifmap_buf_writer #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .start          (start),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_channels   (cfg_channels),
        .cfg_base_addr  (cfg_base_addr),
        .s_axis         (axis),
        .buf_we         (buf_we),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .busy           (busy),
        .done           (done),
        .err_early_last (err_early_last),
        .err_late_last  (err_late_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, h, c, base, last_at, exp_wr;
        bit rnd, exp_early, exp_late;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[6];
    int   checks = 0, errors = 0;
    int   wr_cnt = 0, done_cnt = 0, tready_hi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input vec_t v, input int k);
        int c, pix, r, x;
        c   = k % v.c;
        pix = k / v.c;
        r   = pix / v.w;
        x   = pix % v.w;
        return ADDR_W'(v.base + c * v.h * v.w + r * v.w + x);
    endfunction

    function automatic logic [DATA_W-1:0] elem_data(input int idx, input int k);
        return DATA_W'(k * 7 + idx * 31 + 1);
    endfunction

    // Scoreboard consumer: every buffer write must match the oldest expected write.
    always @(negedge clk) begin
        if (buf_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(buf_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(buf_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(buf_wdata), 32'(mon_e.data));
            end
        end
        if (done) done_cnt++;
        if (axis.tready) tready_hi++;
    end

    task automatic do_start(input vec_t v);
        cfg_width     = DIM_W'(v.w);
        cfg_height    = DIM_W'(v.h);
        cfg_channels  = DIM_W'(v.c);
        cfg_base_addr = ADDR_W'(v.base);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents elements 0..stop_at-1; expected writes are queued as each element is first driven.
    task automatic feed(input vec_t v, input int idx, input int stop_at);
        int  k = 0, pushed = 0, guard = 0;
        bit  hs;
        while (k < stop_at && guard < 2000) begin
            axis.tvalid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axis.tdata  = elem_data(idx, k);
            axis.tlast  = (k + 1 == v.last_at);
            if (k < v.exp_wr && pushed == k) begin
                exp_q.push_back({exp_addr(v, k), elem_data(idx, k)});
                pushed++;
            end
            @(negedge clk);
            hs = axis.tvalid && axis.tready;
            @(posedge clk);
            #1;
            if (hs) k++;
            guard++;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        if (guard >= 2000) chk("feed_timeout", 32'(k), 32'(stop_at));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int lat;
        wr_cnt   = 0;
        done_cnt = 0;
        do_start(v);
        feed(v, idx, v.last_at);
        wait_done(lat);
        chk($sformatf("v%0d_done_latency", idx), 32'(lat), 32'(DoneLat));
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_write_count", idx), 32'(wr_cnt), 32'(v.exp_wr));
        chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_err_early", idx), 32'(err_early_last), 32'(v.exp_early));
        chk($sformatf("v%0d_err_late", idx), 32'(err_late_last), 32'(v.exp_late));
        chk($sformatf("v%0d_sb_empty", idx), 32'(exp_q.size()), 32'd0);
        chk($sformatf("v%0d_idle_tready", idx), 32'(axis.tready), 32'd0);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 32'(axis.tready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_we"}, 32'(buf_we), 32'd0);
        chk({tag, "_addr"}, 32'(buf_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(buf_wdata), 32'd0);
        chk({tag, "_errs"}, {30'd0, err_early_last, err_late_last}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vz;
        int   lat;

        vecs[0] = '{w:4, h:3, c:2, base:'h100,  last_at:24, exp_wr:24, rnd:0, exp_early:0, exp_late:0};
        vecs[1] = '{w:4, h:3, c:2, base:'h100,  last_at:24, exp_wr:24, rnd:1, exp_early:0, exp_late:0};
        vecs[2] = '{w:4, h:3, c:2, base:'h100,  last_at:10, exp_wr:10, rnd:0, exp_early:1, exp_late:0};
        vecs[3] = '{w:4, h:3, c:2, base:'h100,  last_at:27, exp_wr:24, rnd:0, exp_early:0, exp_late:1};
        vecs[4] = '{w:3, h:2, c:3, base:'h3FFE, last_at:18, exp_wr:18, rnd:1, exp_early:0, exp_late:0};
        vecs[5] = '{w:1, h:1, c:1, base:'h005,  last_at:1,  exp_wr:1,  rnd:0, exp_early:0, exp_late:0};

        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Zero channel count: done with no handshake and no writes.
        vz = '{w:4, h:3, c:0, base:'h100, last_at:0, exp_wr:0, rnd:0, exp_early:0, exp_late:0};
        wr_cnt    = 0;
        done_cnt  = 0;
        tready_hi = 0;
        do_start(vz);
        wait_done(lat);
        chk("zero_done_within_2", 32'(lat <= 2), 32'd1);
        repeat (4) @(negedge clk);
        chk("zero_writes", 32'(wr_cnt), 32'd0);
        chk("zero_tready", 32'(tready_hi), 32'd0);
        chk("zero_done_pulses", 32'(done_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Reset during cycle 5 of a frame, then a clean frame.
        done_cnt = 0;
        do_start(vecs[0]);
        feed(vecs[0], 7, 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        run_frame(vecs[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifmap_buf_writer.md
Name: ifmap_buf_writer

Overview:
- Sits directly downstream of the ifmap AXIS bridge and consumes its slave-side stream of ifmap bytes from the DMA.
- Input order is HWC: channel is fastest, then column, then row.
- Each accepted element is written into the ifmap SRAM in CHW (planar) layout, which the im2col/GEMM stage reads.
- Per frame, the block checks the received element count against TLAST.

Parameters:
- DATA_W, 8, element width in bits; equals the bridge TDATA width.
- DIM_W, 8, width of each dimension config field (max 255).
- ADDR_W, 14, buffer word address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- S_AXIS_ACLK  in  1  single clock.
- S_AXIS_ARESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- cfg_width  in  DIM_W  ifmap W.
- cfg_height  in  DIM_W  ifmap H.
- cfg_channels  in  DIM_W  ifmap C.
- cfg_base_addr  in  ADDR_W  buffer address of element (c=0,r=0,x=0).
- S_AXIS_TDATA  in  DATA_W  ifmap element.
- S_AXIS_TVALID  in  1  element valid.
- S_AXIS_TLAST  in  1  last element of frame.
- S_AXIS_TREADY  out  1  element accepted when TVALID && TREADY.
- buf_we  out  1  buffer write enable.
- buf_addr  out  ADDR_W  buffer write address.
- buf_wdata  out  DATA_W  buffer write data.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at frame end.
- err_early_last  out  1  sticky; TLAST seen before W*H*C elements.
- err_late_last  out  1  sticky; no TLAST on element W*H*C.

Behaviour:
- Reset, synchronous and active-high: state=IDLE; all outputs 0; counters 0. Sticky errors clear on reset and on accepted start.
- cfg_* is sampled on start into registers. plane = H*W is registered at the same time, truncated to ADDR_W.
- If any dimension is 0, go to DONE_S directly: no TREADY, no writes, done is pulsed.
- State IDLE: TREADY=0. On start with nonzero dims, go to RUN.
- State RUN: TREADY=1. On each handshake:
  - buf_we=1, buf_wdata=TDATA, buf_addr=ptr.
  - Counters advance c, then x, then r.
  - Address is incremental with no multiplier in the loop. ptr holds base + c*plane + r*W + x.
  - Advancing c: ptr += plane.
  - c wraps to 0: ptr = pix_base + 1, then pix_base += 1. pix_base starts at cfg_base_addr.
- End of frame, at element W*H*C:
  - With TLAST=1: go to DONE_S.
  - With TLAST=0: set err_late_last and go to DRAIN.
- TLAST on an earlier element: that element is written, err_early_last is set, then go to DONE_S.
- State DRAIN: TREADY=1, buf_we=0, excess elements are discarded. When an element with TLAST is accepted, go to DONE_S.
- State DONE_S: done=1 for exactly one cycle, then IDLE.
- Without the optional feature, the write port is combinational from the handshake (0-cycle latency).
- Throughput is 1 element/cycle. TVALID low stalls with no state change.
- start while busy has no effect.
- Reset asserted mid-frame aborts immediately: no done pulse, buffer contents undefined.

Optional Feature:
- Macro: IFMAP_WR_PIPE_EN.
- When defined:
  - buf_we, buf_addr and buf_wdata are registered, giving 1-cycle latency after the handshake.
  - done is delayed one cycle so it follows the final write.
  - TREADY is unaffected.
- When undefined: combinational write port as in Behaviour.

Decomposition:
- Shared config.v holds the state encodings (IDLE, RUN, DRAIN, DONE_S) and the default DIM_W/ADDR_W defines.
- Sub-module ifmap_addr_gen holds the c/x/r counters, plane/pix_base/ptr registers and the last-element flag.
- The top-level block keeps the FSM, the handshake, the error flags and the optional pipeline.

Test Plan:
- W=4, H=3, C=2, base=0x100, continuous TVALID, TLAST on element 24:
  - 24 writes.
  - Element k=(r*4+x)*2+c lands at 0x100+c*12+r*4+x; element 1 lands at 0x10C.
  - done pulses once; both error flags stay 0.
- Same config with TVALID toggling randomly at 50%:
  - Identical address/data sequence.
  - No writes while TVALID=0.
- TLAST on element 10 of 24:
  - 10 writes.
  - err_early_last=1, done pulses, state returns to IDLE, TREADY=0.
- No TLAST on element 24; TLAST on element 27:
  - 24 writes, err_late_last=1.
  - Elements 25-27 accepted with buf_we=0; done one cycle after element 27.
- cfg_channels=0 with start:
  - done pulses within 2 cycles.
  - TREADY never rises; no writes.
- Reset asserted on cycle 5 of a frame:
  - Next cycle all outputs are 0 and state is IDLE.
  - A fresh start then completes normally.
